// File: rtl/thiele_coproc_arbiter.sv
// Round-robin arbiter that lets NUM_CH requesters share one coprocessor engine port,
// with valid/ready issue, a per-request timeout and saturating service/timeout counters.
module thiele_coproc_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]          ch_err,
    output logic                       eng_valid,
    input  logic                       eng_ready,
    output logic [ADDR_W-1:0]          eng_addr,
    output logic [$clog2(NUM_CH)-1:0]  eng_ch,
    input  logic                       eng_rsp_valid,
    input  logic [DATA_W-1:0]          eng_rsp_data,
    input  logic                       eng_rsp_err,
    output logic                       busy,
    output logic [CNT_W-1:0]           svc_count,
    output logic [CNT_W-1:0]           timeout_count
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                     state_q, state_d;
    logic [CH_W-1:0]            ptr_q, ptr_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [NUM_CH-1:0]          ack_prev_q;
    logic [NUM_CH-1:0]          ch_ack_q, ch_ack_d;
    logic [NUM_CH-1:0]          ch_err_q, ch_err_d;
    logic [NUM_CH*DATA_W-1:0]   ch_data_q, ch_data_d;
    logic                       eng_valid_q, eng_valid_d;
    logic [ADDR_W-1:0]          eng_addr_q, eng_addr_d;
    logic [CH_W-1:0]            eng_ch_q, eng_ch_d;
    logic                       busy_q, busy_d;
    logic [CNT_W-1:0]           svc_q, svc_d;
    logic [CNT_W-1:0]           to_q, to_d;

    logic [NUM_CH-1:0]          eligible;
    logic                       found;
    logic [CH_W-1:0]            gnt_idx;
    logic [CH_W-1:0]            cand_idx;
    logic                       timed_out;

    // The requester acked last cycle is skipped for one cycle so it can drop its request.
    assign eligible  = ch_req & ~ack_prev_q;
    assign timed_out = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT));

    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_idx = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (!found && eligible[cand_idx]) begin
                found   = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        ch_ack_d    = '0;
        ch_err_d    = '0;
        ch_data_d   = ch_data_q;
        eng_valid_d = eng_valid_q;
        eng_addr_d  = eng_addr_q;
        eng_ch_d    = eng_ch_q;
        svc_d       = svc_q;
        to_d        = to_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    eng_addr_d  = ch_addr[gnt_idx*ADDR_W +: ADDR_W];
                    eng_ch_d    = gnt_idx;
                    ptr_d       = gnt_idx;
                    timer_d     = '0;
                    eng_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = timer_q + TMR_W'(1);
                if (timed_out) begin
                    eng_valid_d        = 1'b0;
                    ch_ack_d[eng_ch_q] = 1'b1;
                    ch_err_d[eng_ch_q] = 1'b1;
                    if (to_q != {CNT_W{1'b1}}) to_d = to_q + CNT_W'(1);
                    state_d = S_RESP;
                end else if (eng_ready) begin
                    eng_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A response on the timeout cycle takes precedence over the timeout.
                if (eng_rsp_valid) begin
                    ch_ack_d[eng_ch_q] = 1'b1;
                    ch_err_d[eng_ch_q] = eng_rsp_err;
                    ch_data_d[eng_ch_q*DATA_W +: DATA_W] = eng_rsp_data;
                    if (!eng_rsp_err && svc_q != {CNT_W{1'b1}}) svc_d = svc_q + CNT_W'(1);
                    state_d = S_RESP;
                end else if (timed_out) begin
                    ch_ack_d[eng_ch_q] = 1'b1;
                    ch_err_d[eng_ch_q] = 1'b1;
                    if (to_q != {CNT_W{1'b1}}) to_d = to_q + CNT_W'(1);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= CH_W'(NUM_CH - 1);
            timer_q     <= '0;
            ack_prev_q  <= '0;
            ch_ack_q    <= '0;
            ch_err_q    <= '0;
            ch_data_q   <= '0;
            eng_valid_q <= 1'b0;
            eng_addr_q  <= '0;
            eng_ch_q    <= '0;
            busy_q      <= 1'b0;
            svc_q       <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            ack_prev_q  <= ch_ack_q;
            ch_ack_q    <= ch_ack_d;
            ch_err_q    <= ch_err_d;
            ch_data_q   <= ch_data_d;
            eng_valid_q <= eng_valid_d;
            eng_addr_q  <= eng_addr_d;
            eng_ch_q    <= eng_ch_d;
            busy_q      <= busy_d;
            svc_q       <= svc_d;
            to_q        <= to_d;
        end
    end

    assign ch_ack        = ch_ack_q;
    assign ch_err        = ch_err_q;
    assign ch_data       = ch_data_q;
    assign eng_valid     = eng_valid_q;
    assign eng_addr      = eng_addr_q;
    assign eng_ch        = eng_ch_q;
    assign busy          = busy_q;
    assign svc_count     = svc_q;
    assign timeout_count = to_q;
endmodule

// File: tb/tb_thiele_coproc_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized phase,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_thiele_coproc_arbiter;
    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 32;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_CH-1:0]         ch_req = '0;
    logic [NUM_CH*ADDR_W-1:0]  ch_addr = '0;
    logic [NUM_CH-1:0]         ch_ack;
    logic [NUM_CH*DATA_W-1:0]  ch_data;
    logic [NUM_CH-1:0]         ch_err;
    logic                      eng_valid;
    logic                      eng_ready = 1'b0;
    logic [ADDR_W-1:0]         eng_addr;
    logic [1:0]                eng_ch;
    logic                      eng_rsp_valid = 1'b0;
    logic [DATA_W-1:0]         eng_rsp_data = '0;
    logic                      eng_rsp_err = 1'b0;
    logic                      busy;
    logic [CNT_W-1:0]          svc_count;
    logic [CNT_W-1:0]          timeout_count;

    int n_pass  = 0;
    int n_total = 0;

    thiele_coproc_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_addr(ch_addr),
        .ch_ack(ch_ack), .ch_data(ch_data), .ch_err(ch_err),
        .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_addr(eng_addr), .eng_ch(eng_ch),
        .eng_rsp_valid(eng_rsp_valid), .eng_rsp_data(eng_rsp_data), .eng_rsp_err(eng_rsp_err),
        .busy(busy), .svc_count(svc_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_live = 0;
    bit          m_active, m_accepted, m_ack_err;
    int          m_owner, m_age, m_ack_ch, m_prev_ack, m_ptr, m_eng_ch;
    logic [31:0] m_addr;
    logic [31:0] m_data [NUM_CH];
    int unsigned m_svc, m_to;

    always @(posedge clk) begin
        int  win;
        int  c;
        bit  expired;
        if (!rst_n) begin
            m_live = 1; m_active = 0; m_accepted = 0; m_ack_err = 0;
            m_owner = 0; m_age = 0; m_ack_ch = -1; m_prev_ack = -1;
            m_ptr = NUM_CH - 1; m_eng_ch = 0; m_addr = '0;
            for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
            m_svc = 0; m_to = 0;
        end else if (m_live) begin
            if (m_ack_ch >= 0) begin
                m_prev_ack = m_ack_ch;
                m_ack_ch   = -1;
                m_ack_err  = 0;
            end else if (!m_active) begin
                win = -1;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_ptr + k) % NUM_CH;
                    if (win < 0 && ch_req[c] && c != m_prev_ack) win = c;
                end
                m_prev_ack = -1;
                if (win >= 0) begin
                    m_active = 1; m_accepted = 0; m_age = 0;
                    m_owner = win; m_ptr = win; m_eng_ch = win;
                    m_addr = ch_addr[win*ADDR_W +: ADDR_W];
                end
            end else begin
                m_prev_ack = -1;
                expired = (m_age == TIMEOUT);
                if (m_accepted && eng_rsp_valid) begin
                    m_data[m_owner] = eng_rsp_data;
                    m_ack_err = eng_rsp_err;
                    if (!eng_rsp_err) m_svc++;
                    m_ack_ch = m_owner; m_active = 0;
                end else if (expired) begin
                    m_ack_err = 1; m_to++;
                    m_ack_ch = m_owner; m_active = 0;
                end else if (!m_accepted && eng_ready) begin
                    m_accepted = 1;
                end
                m_age++;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [NUM_CH-1:0]        e_ack;
        logic [NUM_CH*DATA_W-1:0] e_data;
        if (m_live) begin
            e_ack = '0;
            if (m_ack_ch >= 0) e_ack[m_ack_ch] = 1'b1;
            for (int i = 0; i < NUM_CH; i++) e_data[i*DATA_W +: DATA_W] = m_data[i];
            check("m_eng_valid", eng_valid, m_active && !m_accepted);
            check("m_eng_addr", eng_addr, m_addr);
            check("m_eng_ch", eng_ch, m_eng_ch);
            check("m_ch_ack", ch_ack, e_ack);
            check("m_ch_err", ch_err, m_ack_err ? e_ack : '0);
            check("m_ch_data", ch_data, e_data);
            check("m_busy", busy, m_active || (m_ack_ch >= 0));
            if (m_ack_ch < 0) begin
                check("m_svc_count", svc_count, m_svc);
                check("m_timeout_count", timeout_count, m_to);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_addr(input int ch, input logic [31:0] a);
        ch_addr[ch*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ack"}, ch_ack, '0);
        check({tag, "_err"}, ch_err, '0);
        check({tag, "_data"}, ch_data, '0);
        check({tag, "_valid"}, eng_valid, 1'b0);
        check({tag, "_addr"}, eng_addr, '0);
        check({tag, "_ch"}, eng_ch, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_svc"}, svc_count, '0);
        check({tag, "_to"}, timeout_count, '0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; ch_req = '0; eng_ready = 1'b0; eng_rsp_valid = 1'b0; eng_rsp_err = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("wait_idle", busy, 1'b0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants [5];
        int ng;
        logic prev_valid;
        int bias;

        // Reset state, then single request on channel 0.
        do_reset();
        check_zero_outputs("rst");
        ch_req = 4'b0001; set_addr(0, 32'h40); eng_ready = 1'b1;
        tick();                                            // cycle 1
        check("sr_valid_c1", eng_valid, 1'b1);
        check("sr_addr_c1", eng_addr, 32'h40);
        check("sr_ch_c1", eng_ch, 2'd0);
        ch_req = '0;
        tick();                                            // cycle 2
        check("sr_noack_c2", ch_ack, 4'b0000);
        eng_rsp_valid = 1'b1; eng_rsp_data = 32'hABCD1234;
        tick();                                            // cycle 3
        eng_rsp_valid = 1'b0;
        check("sr_ack_c3", ch_ack, 4'b0001);
        check("sr_err_c3", ch_err, 4'b0000);
        check("sr_data_c3", ch_data[31:0], 32'hABCD1234);
        tick();                                            // cycle 4
        check("sr_svc_c4", svc_count, 32'd1);
        check("sr_idle_c4", busy, 1'b0);

        // Round robin with every channel requesting.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_addr(i, 32'h100 * (i + 1));
        ch_req = 4'b1111; eng_ready = 1'b1; eng_rsp_valid = 1'b1; eng_rsp_data = 32'hC0DE0001;
        for (int i = 0; i < 5; i++) grants[i] = -1;
        ng = 0; prev_valid = 1'b0;
        for (int n = 0; n < 60 && ng < 5; n++) begin
            tick();
            if (eng_valid === 1'b1 && prev_valid !== 1'b1) begin
                grants[ng] = int'(eng_ch);
                ng++;
            end
            prev_valid = eng_valid;
        end
        ch_req = '0;
        check("rr_grant0", grants[0], 0);
        check("rr_grant1", grants[1], 1);
        check("rr_grant2", grants[2], 2);
        check("rr_grant3", grants[3], 3);
        check("rr_grant4", grants[4], 0);
        wait_idle();

        // Backpressure: ready held low through five ISSUE cycles.
        ch_req = 4'b0100; set_addr(2, 32'hBEEF0200); eng_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();                                        // cycle i
            if (i == 1) ch_req = '0;
            check("bp_hold", {eng_valid, eng_ch, eng_addr}, {1'b1, 2'd2, 32'hBEEF0200});
            check("bp_noack", ch_ack, 4'b0000);
            if (i == 6) eng_ready = 1'b1;
        end
        tick();                                            // cycle 7
        check("bp_wait_c7", eng_valid, 1'b0);
        check("bp_noack_c7", ch_ack, 4'b0000);
        tick();                                            // cycle 8
        check("bp_ack_c8", ch_ack, 4'b0100);
        check("bp_data_c8", ch_data[95:64], 32'hC0DE0001);
        eng_rsp_valid = 1'b0;
        wait_idle();

        // Timeout with no response.
        do_reset();
        ch_req = 4'b0010; set_addr(1, 32'h1000); eng_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) ch_req = '0;
            check("to_noack", ch_ack, 4'b0000);
        end
        tick();                                            // cycle 10
        check("to_ack_c10", ch_ack, 4'b0010);
        check("to_err_c10", ch_err, 4'b0010);
        check("to_data_c10", ch_data, '0);
        tick();
        check("to_count", timeout_count, 32'd1);
        check("to_svc", svc_count, 32'd0);
        tick();

        // Response arriving on the timeout cycle wins.
        ch_req = 4'b0010;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) ch_req = '0;
            if (i == 9) begin
                eng_rsp_valid = 1'b1; eng_rsp_data = 32'h12345678;
            end
        end
        tick();                                            // cycle 10
        eng_rsp_valid = 1'b0;
        check("col_ack", ch_ack, 4'b0010);
        check("col_err", ch_err, 4'b0000);
        check("col_data", ch_data[63:32], 32'h12345678);
        tick();
        check("col_to_count", timeout_count, 32'd1);
        check("col_svc", svc_count, 32'd1);
        wait_idle();

        // Reset pulsed while waiting for a response.
        ch_req = 4'b1000; set_addr(3, 32'h3000); set_addr(0, 32'h5000); eng_ready = 1'b1;
        tick();                                            // cycle 1
        ch_req = '0;
        tick();                                            // cycle 2 (waiting)
        rst_n = 1'b0;
        tick();
        check_zero_outputs("rw");
        rst_n = 1'b1; ch_req = 4'b1001;
        tick();
        check("rw_grant_ch", {eng_valid, eng_ch}, {1'b1, 2'd0});
        check("rw_grant_addr", eng_addr, 32'h5000);
        ch_req = '0;
        wait_idle();

        // Randomized traffic with varying engine readiness and occasional resets.
        bias = 9;
        for (int n = 0; n < 2500; n++) begin
            tick();
            if (n % 100 == 0) bias = $urandom_range(0, 9);
            rst_n = ($urandom_range(0, 399) != 0);
            ch_req = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_req[i] = ($urandom_range(0, 9) < 4);
                ch_addr[i*ADDR_W +: ADDR_W] = $urandom;
            end
            eng_ready     = ($urandom_range(0, 9) < bias);
            eng_rsp_valid = ($urandom_range(0, 9) < 4);
            eng_rsp_err   = ($urandom_range(0, 19) < 3);
            eng_rsp_data  = $urandom;
        end
        rst_n = 1'b1; ch_req = '0; eng_rsp_valid = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/thiele_coproc_arbiter.md
# thiele_coproc_arbiter

Parametrised multi-channel coprocessor request arbiter for the Thiele CPU's off-core engines. It generalises the single-channel logic-engine and Python-execution req/ack handshakes to NUM_CH requesters sharing one engine port. It adds round-robin fairness, valid/ready issue, a per-request timeout with an error flag, and service/timeout counters. It sits between the CPU's `*_req/*_ack` ports and a shared engine.

## Interface
- NUM_CH, 4: requester channels (2..16)
- ADDR_W, 32: request address width
- DATA_W, 32: response data width
- TIMEOUT, 255: max cycles from grant to response; 0 disables timeout
- CNT_W, 32: statistics counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ch_req  in  NUM_CH  level request per channel
- ch_addr  in  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
- ch_ack  out  NUM_CH  one-cycle completion pulse
- ch_data  out  NUM_CH*DATA_W  per-channel response, held until that channel's next ack
- ch_err  out  NUM_CH  timeout/engine-error flag, valid with ch_ack
- eng_valid  out  1  request to engine
- eng_ready  in  1  engine accepts request
- eng_addr  out  ADDR_W  latched address of granted channel
- eng_ch  out  $clog2(NUM_CH)  granted channel index
- eng_rsp_valid  in  1  engine response strobe
- eng_rsp_data  in  DATA_W  response payload
- eng_rsp_err  in  1  engine-reported error
- busy  out  1  state != IDLE
- svc_count  out  CNT_W  error-free completions, saturating
- timeout_count  out  CNT_W  timeouts, saturating

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Reset: state=IDLE. ch_ack, ch_err, ch_data, eng_valid, eng_addr, eng_ch, busy and both counters are 0. The round-robin pointer is NUM_CH-1, so channel 0 has first priority.
- IDLE:
  - Eligible channels are those with ch_req=1, excluding the channel acked in the previous cycle. This masks one cycle so a requester can drop req.
  - Grant the first eligible channel searching from pointer+1 with wrap.
  - On grant, latch the address into eng_addr, set eng_ch and pointer to the winner, clear the timer, and go to ISSUE.
- ISSUE:
  - eng_valid=1; eng_addr and eng_ch are stable.
  - On eng_ready=1, go to WAIT.
  - Withdrawal of ch_req after grant is ignored; the request completes.
- WAIT:
  - On eng_rsp_valid=1, latch data and err=eng_rsp_err, then go to RESP.
- Timeout:
  - The timer increments every cycle in ISSUE and WAIT.
  - When timer==TIMEOUT (TIMEOUT≠0) and no response arrives that cycle, go to RESP with err=1.
  - On timeout the data is left unchanged and eng_valid drops (request aborted).
  - A response in the same cycle as a timeout wins.
- RESP:
  - ch_ack[eng_ch]=1 and ch_err[eng_ch]=err for exactly one cycle.
  - ch_data[eng_ch] is updated only when there is a response.
  - svc_count increments if the response is error-free; timeout_count increments on timeout.
  - Go to IDLE.
- eng_rsp_valid outside WAIT is a stray response: ignored with no side effects.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted in any state returns the block to reset values on the next edge. No ack is emitted for the aborted request.

## Timing
- Minimum latency, request to ack, is 3 cycles (engine ready and response with no wait):
  - cycle 0: IDLE samples req
  - cycle 1: ISSUE, eng_valid
  - cycle 2: WAIT, eng_rsp_valid
  - cycle 3: RESP, ch_ack
  - cycle 4: IDLE, requester masked
- Throughput is one request per 4 cycles minimum.
- A timeout occurs exactly TIMEOUT+1 cycles after entering ISSUE; ack follows one cycle later.
- ch_ack is never asserted on more than one channel in the same cycle.

## Test plan
- Single request: ch_req[0]=1, addr=0x40, engine ready immediately, response 0xABCD1234 next cycle. Required: eng_valid in cycle 1, ch_ack[0] in cycle 3, ch_data[0]=0xABCD1234, ch_err=0, svc_count=1.
- Round-robin: all 4 reqs held high. Required: grant order 0,1,2,3,0; each ack one-hot; no channel granted twice before the others are served.
- Backpressure: eng_ready low for 5 cycles. Required: eng_valid, eng_addr and eng_ch stable throughout; WAIT entered on the ready cycle; ack arrives 5 cycles later than the baseline.
- Timeout: TIMEOUT=8, no response. Required: ch_ack with ch_err=1, ch_data unchanged, timeout_count=1, svc_count=0.
- Timeout/response collision: TIMEOUT=8, eng_rsp_valid on the timeout cycle with 0x12345678. Required: ch_err=0, data latched, timeout_count unchanged.
- Reset in WAIT: rst_n=0 for one cycle mid-WAIT. Required: all outputs 0, no ack, and the next request goes to channel 0 first.
